smc_cram_seq: RTL and testbench

- SMC-side sequencer that generates the smc_* strobe set consumed by the CRAM control logic: write, read, precharge, pull, word-line and CRAM-clear controls.
- Takes single-cycle frame-operation requests (write, read, clear) from the configuration engine and plays out one timed strobe sequence per request.
- Reports busy/done back to the engine.
- Sits between the config engine and the CRAM control logic in the iCE8P bank periphery.

---
 rtl/smc_cram_seq.sv | 164 ++++++++++++++++
 tb/tb_smc_cram_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/smc_cram_seq.sv
// rtl/smc_cram_seq.sv - SMC strobe sequencer for CRAM frame write, read and clear
// Every output is a flop decoded from next-state so downstream clock/reset pins see no glitches.
module smc_cram_seq #(
  parameter int PREC_CYC = 2,
  parameter int PULL_CYC = 2,
  parameter int WL_CYC   = 4
) (
  input  logic smc_clk,
  input  logic por_b,
  input  logic req_write,
  input  logic req_read,
  input  logic req_clr,
  output logic busy,
  output logic done,
  output logic smc_write,
  output logic smc_read,
  output logic smc_seq_rst,
  output logic smc_wset_prec,
  output logic smc_wset_precgnd,
  output logic smc_wwlwrt_en,
  output logic smc_wwlwrt_dis,
  output logic smc_wcram_rst,
  output logic smc_rprec,
  output logic smc_rpull_b,
  output logic smc_rwl_en,
  output logic smc_rrst_pullwlen
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_W_SETUP = 4'd1;
  localparam logic [3:0] S_W_PREC  = 4'd2;
  localparam logic [3:0] S_W_WL    = 4'd3;
  localparam logic [3:0] S_W_WLDIS = 4'd4;
  localparam logic [3:0] S_R_SETUP = 4'd5;
  localparam logic [3:0] S_R_PREC  = 4'd6;
  localparam logic [3:0] S_R_PULL  = 4'd7;
  localparam logic [3:0] S_R_WL    = 4'd8;
  localparam logic [3:0] S_R_RST   = 4'd9;
  localparam logic [3:0] S_C_SETUP = 4'd10;
  localparam logic [3:0] S_C_RST   = 4'd11;
  localparam logic [3:0] S_END     = 4'd12;

  localparam logic [3:0] PREC_LD = 4'(PREC_CYC - 1);
  localparam logic [3:0] PULL_LD = 4'(PULL_CYC - 1);
  localparam logic [3:0] WL_LD   = 4'(WL_CYC - 1);

  localparam int O_BUSY  = 13;
  localparam int O_DONE  = 12;
  localparam int O_WR    = 11;
  localparam int O_RD    = 10;
  localparam int O_SEQ   = 9;
  localparam int O_WPREC = 8;
  localparam int O_WPGND = 7;
  localparam int O_WLEN  = 6;
  localparam int O_WLDIS = 5;
  localparam int O_CRAM  = 4;
  localparam int O_RPREC = 3;
  localparam int O_RPULL = 2;
  localparam int O_RWL   = 1;
  localparam int O_RRST  = 0;

  localparam logic [13:0] OUT_IDLE = 14'h0204;

  logic [3:0]  state_d, state_q;
  logic [3:0]  cnt_d, cnt_q;
  logic [13:0] out_d, out_q;
  logic        cnt_zero;

  assign cnt_zero = (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (req_clr)        state_d = S_C_SETUP;
        else if (req_write) state_d = S_W_SETUP;
        else if (req_read)  state_d = S_R_SETUP;
      end
      S_W_SETUP: begin state_d = S_W_PREC; cnt_d = PREC_LD; end
      S_W_PREC: begin
        if (cnt_zero) begin state_d = S_W_WL; cnt_d = WL_LD; end
        else cnt_d = cnt_q - 4'd1;
      end
      S_W_WL: begin
        if (cnt_zero) state_d = S_W_WLDIS;
        else cnt_d = cnt_q - 4'd1;
      end
      S_W_WLDIS: state_d = S_END;
      S_R_SETUP: begin state_d = S_R_PREC; cnt_d = PREC_LD; end
      S_R_PREC: begin
        if (cnt_zero) begin state_d = S_R_PULL; cnt_d = PULL_LD; end
        else cnt_d = cnt_q - 4'd1;
      end
      S_R_PULL: begin
        if (cnt_zero) begin state_d = S_R_WL; cnt_d = WL_LD; end
        else cnt_d = cnt_q - 4'd1;
      end
      S_R_WL: begin
        if (cnt_zero) state_d = S_R_RST;
        else cnt_d = cnt_q - 4'd1;
      end
      S_R_RST:   state_d = S_END;
      S_C_SETUP: begin state_d = S_C_RST; cnt_d = WL_LD; end
      S_C_RST: begin
        if (cnt_zero) state_d = S_END;
        else cnt_d = cnt_q - 4'd1;
      end
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes follow the state being entered, so they settle on the same edge as the state.
  always_comb begin
    out_d = OUT_IDLE;
    if (state_d != S_IDLE && state_d <= S_END) begin
      out_d[O_BUSY] = 1'b1;
      out_d[O_SEQ]  = 1'b0;
    end
    case (state_d)
      S_W_SETUP, S_C_SETUP: out_d[O_WR] = 1'b1;
      S_W_PREC:  begin out_d[O_WR] = 1'b1; out_d[O_WPREC] = 1'b1; out_d[O_WPGND] = 1'b1; end
      S_W_WL:    begin out_d[O_WR] = 1'b1; out_d[O_WLEN] = 1'b1; end
      S_W_WLDIS: begin out_d[O_WR] = 1'b1; out_d[O_WLDIS] = 1'b1; end
      S_R_SETUP: out_d[O_RD] = 1'b1;
      S_R_PREC:  begin out_d[O_RD] = 1'b1; out_d[O_RPREC] = 1'b1; end
      S_R_PULL:  begin out_d[O_RD] = 1'b1; out_d[O_RPULL] = 1'b0; end
      S_R_WL:    begin out_d[O_RD] = 1'b1; out_d[O_RPULL] = 1'b0; out_d[O_RWL] = 1'b1; end
      S_R_RST:   begin out_d[O_RD] = 1'b1; out_d[O_RRST] = 1'b1; end
      S_C_RST:   begin out_d[O_WR] = 1'b1; out_d[O_CRAM] = 1'b1; end
      S_END:     begin out_d[O_DONE] = 1'b1; out_d[O_SEQ] = 1'b1; end
      default:   ;
    endcase
  end

  always_ff @(posedge smc_clk or negedge por_b) begin
    if (!por_b) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      out_q   <= OUT_IDLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign busy              = out_q[O_BUSY];
  assign done              = out_q[O_DONE];
  assign smc_write         = out_q[O_WR];
  assign smc_read          = out_q[O_RD];
  assign smc_seq_rst       = out_q[O_SEQ];
  assign smc_wset_prec     = out_q[O_WPREC];
  assign smc_wset_precgnd  = out_q[O_WPGND];
  assign smc_wwlwrt_en     = out_q[O_WLEN];
  assign smc_wwlwrt_dis    = out_q[O_WLDIS];
  assign smc_wcram_rst     = out_q[O_CRAM];
  assign smc_rprec         = out_q[O_RPREC];
  assign smc_rpull_b       = out_q[O_RPULL];
  assign smc_rwl_en        = out_q[O_RWL];
  assign smc_rrst_pullwlen = out_q[O_RRST];

endmodule

// File: tb/tb_smc_cram_seq.sv
// tb/tb_smc_cram_seq.sv - self-checking bench for smc_cram_seq
// Three instances: default timing, WL_CYC=1, and PREC_CYC=WL_CYC=16.
module tb_smc_cram_seq;

  logic smc_clk = 1'b0;
  always #5 smc_clk = ~smc_clk;

  logic por_b;
  logic [2:0] rq_w, rq_r, rq_c;
  logic [2:0] busy_v, done_v, write_v, read_v, seqrst_v, prec_v, precgnd_v;
  logic [2:0] wlen_v, wldis_v, cram_v, rprec_v, rpull_v, rwl_v, rrst_v;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int B_BUSY = 13, B_DONE = 12, B_WR = 11, B_RD = 10, B_SEQ = 9;
  localparam int B_WPREC = 8, B_WPGND = 7, B_WLEN = 6, B_WLDIS = 5, B_CRAM = 4;
  localparam int B_RPREC = 3, B_RPULL = 2, B_RWL = 1, B_RRST = 0;
  localparam logic [13:0] IDLE_V = 14'h0204;

  int prec_of [3] = '{2, 2, 16};
  int pull_of [3] = '{2, 2, 2};
  int wl_of   [3] = '{4, 1, 16};

  smc_cram_seq u0 (
    .smc_clk(smc_clk), .por_b(por_b),
    .req_write(rq_w[0]), .req_read(rq_r[0]), .req_clr(rq_c[0]),
    .busy(busy_v[0]), .done(done_v[0]), .smc_write(write_v[0]), .smc_read(read_v[0]),
    .smc_seq_rst(seqrst_v[0]), .smc_wset_prec(prec_v[0]), .smc_wset_precgnd(precgnd_v[0]),
    .smc_wwlwrt_en(wlen_v[0]), .smc_wwlwrt_dis(wldis_v[0]), .smc_wcram_rst(cram_v[0]),
    .smc_rprec(rprec_v[0]), .smc_rpull_b(rpull_v[0]), .smc_rwl_en(rwl_v[0]),
    .smc_rrst_pullwlen(rrst_v[0])
  );

  smc_cram_seq #(.WL_CYC(1)) u1 (
    .smc_clk(smc_clk), .por_b(por_b),
    .req_write(rq_w[1]), .req_read(rq_r[1]), .req_clr(rq_c[1]),
    .busy(busy_v[1]), .done(done_v[1]), .smc_write(write_v[1]), .smc_read(read_v[1]),
    .smc_seq_rst(seqrst_v[1]), .smc_wset_prec(prec_v[1]), .smc_wset_precgnd(precgnd_v[1]),
    .smc_wwlwrt_en(wlen_v[1]), .smc_wwlwrt_dis(wldis_v[1]), .smc_wcram_rst(cram_v[1]),
    .smc_rprec(rprec_v[1]), .smc_rpull_b(rpull_v[1]), .smc_rwl_en(rwl_v[1]),
    .smc_rrst_pullwlen(rrst_v[1])
  );

  smc_cram_seq #(.PREC_CYC(16), .WL_CYC(16)) u2 (
    .smc_clk(smc_clk), .por_b(por_b),
    .req_write(rq_w[2]), .req_read(rq_r[2]), .req_clr(rq_c[2]),
    .busy(busy_v[2]), .done(done_v[2]), .smc_write(write_v[2]), .smc_read(read_v[2]),
    .smc_seq_rst(seqrst_v[2]), .smc_wset_prec(prec_v[2]), .smc_wset_precgnd(precgnd_v[2]),
    .smc_wwlwrt_en(wlen_v[2]), .smc_wwlwrt_dis(wldis_v[2]), .smc_wcram_rst(cram_v[2]),
    .smc_rprec(rprec_v[2]), .smc_rpull_b(rpull_v[2]), .smc_rwl_en(rwl_v[2]),
    .smc_rrst_pullwlen(rrst_v[2])
  );

  function automatic logic [13:0] obs(int i);
    return {busy_v[i], done_v[i], write_v[i], read_v[i], seqrst_v[i], prec_v[i], precgnd_v[i],
            wlen_v[i], wldis_v[i], cram_v[i], rprec_v[i], rpull_v[i], rwl_v[i], rrst_v[i]};
  endfunction

  // op: 0 none, 1 write, 2 read, 3 clear
  function automatic int total_of(int op, int inst);
    case (op)
      1: return 3 + prec_of[inst] + wl_of[inst];
      2: return 3 + prec_of[inst] + pull_of[inst] + wl_of[inst];
      3: return 2 + wl_of[inst];
      default: return 0;
    endcase
  endfunction

  // Expected strobe set in the k-th cycle after the accepting edge, from the segment lengths.
  function automatic logic [13:0] exp_vec(int op, int k, int inst);
    logic [13:0] v;
    int p, u, w, total;
    p = prec_of[inst]; u = pull_of[inst]; w = wl_of[inst];
    total = total_of(op, inst);
    v = IDLE_V;
    if (k >= total) return v;
    v[B_BUSY] = 1'b1;
    v[B_SEQ]  = 1'b0;
    if (k == total - 1) begin
      v[B_DONE] = 1'b1;
      v[B_SEQ]  = 1'b1;
      return v;
    end
    case (op)
      1: begin
        v[B_WR] = 1'b1;
        if (k >= 1 && k <= p) begin v[B_WPREC] = 1'b1; v[B_WPGND] = 1'b1; end
        else if (k > p && k <= p + w) v[B_WLEN] = 1'b1;
        else if (k == p + w + 1) v[B_WLDIS] = 1'b1;
      end
      2: begin
        v[B_RD] = 1'b1;
        if (k >= 1 && k <= p) v[B_RPREC] = 1'b1;
        else if (k > p && k <= p + u) v[B_RPULL] = 1'b0;
        else if (k > p + u && k <= p + u + w) begin v[B_RPULL] = 1'b0; v[B_RWL] = 1'b1; end
        else if (k == p + u + w + 1) v[B_RRST] = 1'b1;
      end
      3: begin
        v[B_WR] = 1'b1;
        if (k >= 1 && k <= w) v[B_CRAM] = 1'b1;
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic check_vec(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    rq_w = 3'b000; rq_r = 3'b000; rq_c = 3'b000;
  endtask

  // Pulse a request for one edge, then compare every cycle until back in IDLE (bounded loop).
  task automatic run_seq(input int inst, input logic c, input logic w, input logic r,
                         input bit noise, input string name,
                         output int nbusy, output int nwr, output int ndone,
                         output int nprec, output int nwlen, output int ncram);
    int op, total;
    logic [13:0] o;
    op = c ? 3 : (w ? 1 : (r ? 2 : 0));
    total = total_of(op, inst);
    nbusy = 0; nwr = 0; ndone = 0; nprec = 0; nwlen = 0; ncram = 0;
    @(negedge smc_clk);
    rq_c[inst] = c; rq_w[inst] = w; rq_r[inst] = r;
    for (int k = 0; k <= total + 1; k++) begin
      @(posedge smc_clk);
      #1;
      o = obs(inst);
      check_vec(name, o, exp_vec(op, k, inst));
      if (o[B_BUSY])  nbusy++;
      if (o[B_WR])    nwr++;
      if (o[B_DONE])  ndone = k + 1;
      if (o[B_WPREC]) nprec++;
      if (o[B_WLEN])  nwlen++;
      if (o[B_CRAM])  ncram++;
      @(negedge smc_clk);
      rq_c[inst] = 1'b0; rq_r[inst] = 1'b0;
      rq_w[inst] = noise && (k < total);
    end
    rq_w[inst] = 1'b0;
  endtask

  typedef struct {
    int   inst;
    logic c, w, r;
    bit   noise;
    int   exp_busy, exp_wr, exp_prec, exp_wlen, exp_cram;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int nb, nw, nd, np, nl, nc;
    int mop, mk, total;
    logic [2:0] rnd;

    tbl[0] = '{0, 1'b0, 1'b1, 1'b0, 1'b0, 9,  8,  2,  4,  0};
    tbl[1] = '{0, 1'b0, 1'b0, 1'b1, 1'b0, 11, 0,  0,  0,  0};
    tbl[2] = '{1, 1'b1, 1'b0, 1'b0, 1'b0, 3,  2,  0,  0,  1};
    tbl[3] = '{0, 1'b1, 1'b1, 1'b1, 1'b0, 6,  5,  0,  0,  4};
    tbl[4] = '{1, 1'b1, 1'b0, 1'b0, 1'b1, 3,  2,  0,  0,  1};
    tbl[5] = '{2, 1'b0, 1'b1, 1'b0, 1'b0, 35, 34, 16, 16, 0};
    tbl[6] = '{0, 1'b0, 1'b1, 1'b1, 1'b0, 9,  8,  2,  4,  0};
    tbl[7] = '{0, 1'b1, 1'b0, 1'b0, 1'b1, 6,  5,  0,  0,  4};

    clear_reqs();
    por_b = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) check_vec("reset_state", obs(i), IDLE_V);
    @(negedge smc_clk);
    por_b = 1'b1;

    for (int t = 0; t < 8; t++) begin
      run_seq(tbl[t].inst, tbl[t].c, tbl[t].w, tbl[t].r, tbl[t].noise, $sformatf("vec%0d_cycle", t),
              nb, nw, nd, np, nl, nc);
      check_int($sformatf("vec%0d_busy_cycles", t), nb, tbl[t].exp_busy);
      check_int($sformatf("vec%0d_write_cycles", t), nw, tbl[t].exp_wr);
      check_int($sformatf("vec%0d_done_cycle", t), nd, tbl[t].exp_busy);
      check_int($sformatf("vec%0d_prec_cycles", t), np, tbl[t].exp_prec);
      check_int($sformatf("vec%0d_wlen_cycles", t), nl, tbl[t].exp_wlen);
      check_int($sformatf("vec%0d_cram_cycles", t), nc, tbl[t].exp_cram);
    end

    // Asynchronous reset in the middle of a write, then a clean read.
    @(negedge smc_clk);
    rq_w[0] = 1'b1;
    @(negedge smc_clk);
    rq_w[0] = 1'b0;
    repeat ($urandom_range(1, 5)) @(posedge smc_clk);
    #($urandom_range(1, 4));
    check_int("write_in_progress", int'(busy_v[0]), 1);
    por_b = 1'b0;
    #1;
    check_vec("async_reset_midwrite", obs(0), IDLE_V);
    @(negedge smc_clk);
    check_vec("reset_held", obs(0), IDLE_V);
    por_b = 1'b1;
    run_seq(0, 1'b0, 1'b0, 1'b1, 1'b0, "read_after_reset", nb, nw, nd, np, nl, nc);
    check_int("read_after_reset_busy", nb, 11);

    // Random request traffic against a per-cycle model of accept / run / return-to-idle.
    mop = 0; mk = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge smc_clk);
      rnd[0] = ($urandom_range(0, 3) == 0);
      rnd[1] = ($urandom_range(0, 3) == 0);
      rnd[2] = ($urandom_range(0, 5) == 0);
      rq_w[0] = rnd[0]; rq_r[0] = rnd[1]; rq_c[0] = rnd[2];
      @(posedge smc_clk);
      if (mop == 0) begin
        if (rnd[2])      begin mop = 3; mk = 0; end
        else if (rnd[0]) begin mop = 1; mk = 0; end
        else if (rnd[1]) begin mop = 2; mk = 0; end
      end else begin
        mk++;
        total = total_of(mop, 0);
        if (mk >= total) mop = 0;
      end
      #1;
      check_vec("random_cycle", obs(0), (mop == 0) ? IDLE_V : exp_vec(mop, mk, 0));
    end
    clear_reqs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
